// File: rtl/mux_selfcheck_engine.sv
// Self-checking stimulus/compare engine for an N:1 mux DUT: drives LFSR vectors on I/S,
// compares Y against I[S] after DUT_LAT cycles and reports pass, counts and first failing vector.
module mux_selfcheck_engine #(
  parameter int          N_IN        = 8,
  parameter int          NUM_VEC     = 16,
  parameter int          DUT_LAT     = 0,
  parameter logic [31:0] LFSR_SEED   = 32'hACE12345,
  parameter int          STOP_ON_ERR = 0,
  parameter int          CNT_W       = 16,
  localparam int         SEL_W       = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  I,
  output logic [SEL_W-1:0] S,
  input  logic             Y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] fail_idx
);

  localparam logic [31:0]      POLY = 32'h80200003;
  localparam logic [CNT_W-1:0] NV   = CNT_W'(NUM_VEC);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [31:0]        r_lfsr;
  logic [N_IN-1:0]    r_I;
  logic [SEL_W-1:0]   r_S;
  logic [CNT_W-1:0]   r_ldIdx;
  logic [CNT_W-1:0]   r_vec;
  logic [CNT_W-1:0]   r_err;
  logic [CNT_W-1:0]   r_fail;
  logic               r_pass;
  logic               r_expV [0:DUT_LAT];
  logic               r_expD [0:DUT_LAT];

  logic               w_startAcc;
  logic               w_active;
  logic               w_cmp;
  logic               w_mis;
  logic               w_stop;
  logic               w_last;
  logic               w_load;
  logic [31:0]        w_src;
  logic [N_IN-1:0]    w_srcI;
  logic [SEL_W-1:0]   w_srcS;
  logic               w_exp;
  logic [CNT_W-1:0]   w_errInc;

  function automatic logic [31:0] lfsrStep(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? POLY : 32'h0);
  endfunction

  assign w_startAcc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_active   = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_cmp      = w_active && r_expV[DUT_LAT];
  assign w_mis      = w_cmp && (Y != r_expD[DUT_LAT]);
  assign w_stop     = (STOP_ON_ERR != 0) && w_mis;
  assign w_last     = w_cmp && ((r_vec + 1'b1) == NV);
  // A stopping mismatch also suppresses the load on that edge so I/S freeze on the failing vector
  assign w_load     = w_startAcc || ((r_state == ST_RUN) && (r_ldIdx != NV) && !w_stop);
  assign w_src      = w_startAcc ? LFSR_SEED : r_lfsr;
  assign w_srcI     = w_src[N_IN-1:0];
  assign w_srcS     = w_src[31 -: SEL_W];
  assign w_exp      = w_srcI[w_srcS];
  assign w_errInc   = (r_err == '1) ? r_err : r_err + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_nextState = ST_RUN;
      ST_RUN: begin
        if (w_stop || w_last)   w_nextState = ST_DONE;
        else if (r_ldIdx == NV) w_nextState = ST_DRAIN;
      end
      ST_DRAIN: if (w_stop || w_last) w_nextState = ST_DONE;
      ST_DONE:  if (start) w_nextState = ST_RUN;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr  <= LFSR_SEED;
      r_I     <= '0;
      r_S     <= '0;
      r_ldIdx <= '0;
      r_vec   <= '0;
      r_err   <= '0;
      r_fail  <= '0;
      r_pass  <= 1'b0;
      for (int i = 0; i <= DUT_LAT; i++) begin
        r_expV[i] <= 1'b0;
        r_expD[i] <= 1'b0;
      end
    end else begin
      if (w_startAcc) begin
        r_vec  <= '0;
        r_err  <= '0;
        r_fail <= '0;
        r_pass <= 1'b0;
      end else if (w_cmp) begin
        r_vec <= r_vec + 1'b1;
        if (w_mis) begin
          r_err <= w_errInc;
          if (r_err == '0) r_fail <= r_vec;
        end
        if (w_stop || w_last) r_pass <= (r_err == '0) && !w_mis;
      end
      if (w_load) begin
        r_I     <= w_srcI;
        r_S     <= w_srcS;
        r_lfsr  <= lfsrStep(w_src);
        r_ldIdx <= w_startAcc ? CNT_W'(1) : r_ldIdx + 1'b1;
      end
      // Expected-value pipeline; flushed on stop so discarded vectors never compare
      r_expV[0] <= w_load;
      r_expD[0] <= w_exp;
      for (int i = 1; i <= DUT_LAT; i++) begin
        r_expV[i] <= r_expV[i-1] && !w_stop && !w_startAcc;
        r_expD[i] <= r_expD[i-1];
      end
    end
  end

  assign I         = r_I;
  assign S         = r_S;
  assign busy      = w_active;
  assign done      = (r_state == ST_DONE);
  assign pass      = r_pass;
  assign vec_count = r_vec;
  assign err_count = r_err;
  assign fail_idx  = r_fail;

endmodule
